// File: rtl/sync_pkg.sv
// Shared types and helpers for the sync_manager arbiter slice.
package sync_pkg;

  localparam int LOG_LENGTH_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_t;

  // Limits a requested window exponent so the cycle counter cannot overflow.
  function automatic logic [LOG_LENGTH_WIDTH-1:0] clamp_log_length(
    input logic [LOG_LENGTH_WIDTH-1:0] len,
    input int                          max_len
  );
    logic [LOG_LENGTH_WIDTH-1:0] result;
    result = len;
    if (int'(len) > max_len) result = LOG_LENGTH_WIDTH'(max_len);
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first valid index after the last winner.
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  int idx;

  // Scan farthest-first so the closest valid index after last wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[IDX_W'(idx)]) begin
        found = 1'b1;
        index = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sync_arbiter.sv
// Round-robin arbiter sharing one sync_manager between NUM_REQ requesters,
// each granted a timed window of 2^log_length cycles followed by an ack.
module sync_arbiter
  import sync_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int MAX_LOG_LENGTH = 10,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic                                SYS_aclk,
  input  logic                                SYS_reset,
  input  logic                                ARB_enable,
  input  logic [NUM_REQ-1:0]                  REQ_valid,
  input  logic [LOG_LENGTH_WIDTH*NUM_REQ-1:0] REQ_log_length,
  input  logic [MM_ADDR_WIDTH*NUM_REQ-1:0]    REQ_address,
  output logic [NUM_REQ-1:0]                  REQ_ack,
  output logic [NUM_REQ-1:0]                  ARB_grant,
  output logic                                ARB_busy,
  output logic                                SM_request,
  output logic [LOG_LENGTH_WIDTH-1:0]         SM_log_length,
  output logic [MM_ADDR_WIDTH-1:0]            SM_address
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = MAX_LOG_LENGTH + 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

  state_t                      state;
  logic [CNT_W-1:0]            count;
  logic [IDX_W-1:0]            last;
  logic                        pick_found;
  logic [IDX_W-1:0]            pick_idx;
  logic [LOG_LENGTH_WIDTH-1:0] pick_len;
  logic [MM_ADDR_WIDTH-1:0]    pick_addr;
  logic [CNT_W-1:0]            window_load;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (REQ_valid),
    .last  (last),
    .found (pick_found),
    .index (pick_idx)
  );

  assign pick_len    = clamp_log_length(
                         REQ_log_length[int'(pick_idx)*LOG_LENGTH_WIDTH +: LOG_LENGTH_WIDTH],
                         MAX_LOG_LENGTH);
  assign pick_addr   = REQ_address[int'(pick_idx)*MM_ADDR_WIDTH +: MM_ADDR_WIDTH];
  assign window_load = (CNT_W'(1) << pick_len) - CNT_W'(1);

  // Reset leaves last at the top index so requester 0 is the first winner.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      last          <= IDX_W'(NUM_REQ - 1);
      REQ_ack       <= '0;
      ARB_grant     <= '0;
      ARB_busy      <= 1'b0;
      SM_request    <= 1'b0;
      SM_log_length <= '0;
      SM_address    <= '0;
    end else begin
      REQ_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (ARB_enable && pick_found) begin
            ARB_grant     <= NUM_REQ'(1) << pick_idx;
            SM_request    <= 1'b1;
            SM_address    <= pick_addr;
            SM_log_length <= pick_len;
            ARB_busy      <= 1'b1;
            count         <= window_load;
            last          <= pick_idx;
            state         <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (count == '0) begin
            SM_request <= 1'b0;
            ARB_grant  <= '0;
            REQ_ack    <= ARB_grant;
            if (GUARD_CYCLES == 0) begin
              ARB_busy <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              count <= GUARD_LOAD;
              state <= ST_GUARD;
            end
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_GUARD: begin
          if (count == '0) begin
            ARB_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_arbiter.sv
// Self-checking bench for sync_arbiter: directed table, corner sequences,
// and randomized traffic compared against a timestamp-based reference model.
module tb_sync_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int MAXL    = 10;
  localparam int GUARD   = 2;

  logic            clk;
  logic            rst;
  logic            en;
  logic [1:0]      req_valid;
  logic [9:0]      req_len;
  logic [63:0]     req_addr;
  logic [1:0]      req_ack;
  logic [1:0]      arb_grant;
  logic            arb_busy;
  logic            sm_request;
  logic [4:0]      sm_log_length;
  logic [AW-1:0]   sm_address;

  int checks   = 0;
  int failures = 0;

  // Reference model: edge counter plus window end / next-grant timestamps.
  int          t = 0;
  bit          m_active = 0;
  int          m_win_end = 0;
  int          m_free_at = 0;
  int          m_g = 0;
  int          m_last = NUM_REQ - 1;
  logic        e_req;
  logic [1:0]  e_grant;
  logic [1:0]  e_ack;
  logic        e_busy;
  logic [4:0]  e_len;
  logic [31:0] e_addr;

  sync_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MM_ADDR_WIDTH  (AW),
    .MAX_LOG_LENGTH (MAXL),
    .GUARD_CYCLES   (GUARD)
  ) dut (
    .SYS_aclk       (clk),
    .SYS_reset      (rst),
    .ARB_enable     (en),
    .REQ_valid      (req_valid),
    .REQ_log_length (req_len),
    .REQ_address    (req_addr),
    .REQ_ack        (req_ack),
    .ARB_grant      (arb_grant),
    .ARB_busy       (arb_busy),
    .SM_request     (sm_request),
    .SM_log_length  (sm_log_length),
    .SM_address     (sm_address)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h edge=%0d", name, act, exp, t);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] v,
                               input logic [4:0] l0, input logic [4:0] l1,
                               input logic [31:0] a0, input logic [31:0] a1);
    rst       = r;
    en        = e;
    req_valid = v;
    req_len   = {l1, l0};
    req_addr  = {a1, a0};
  endtask

  // Winner is the valid requester at the smallest circular distance after last.
  task automatic modelStep();
    int best, best_d, d, raw, len;
    t++;
    if (rst) begin
      m_active  = 0;
      m_last    = NUM_REQ - 1;
      m_free_at = t + 1;
      m_win_end = 0;
      e_req = 0; e_grant = 0; e_ack = 0; e_busy = 0; e_len = 0; e_addr = 0;
      return;
    end
    e_ack = 0;
    if (m_active && t == m_win_end) begin
      e_req    = 0;
      e_grant  = 0;
      e_ack    = 2'(1 << m_g);
      m_active = 0;
    end else if (!m_active && t >= m_free_at && en && (req_valid != 0)) begin
      best = -1;
      best_d = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        d = (i - m_last - 1 + NUM_REQ) % NUM_REQ;
        if (req_valid[i] && d < best_d) begin
          best = i;
          best_d = d;
        end
      end
      m_g       = best;
      m_last    = best;
      raw       = int'(req_len[5*best +: 5]);
      len       = (raw > MAXL) ? MAXL : raw;
      e_len     = 5'(len);
      e_addr    = req_addr[32*best +: 32];
      e_req     = 1;
      e_grant   = 2'(1 << best);
      m_win_end = t + (1 << len);
      m_free_at = m_win_end + GUARD + 1;
      m_active  = 1;
    end
    e_busy = m_active || (t < m_free_at - 1);
  endtask

  task automatic checkOutput();
    check("SM_request", 64'(sm_request), 64'(e_req));
    check("ARB_grant", 64'(arb_grant), 64'(e_grant));
    check("REQ_ack", 64'(req_ack), 64'(e_ack));
    check("ARB_busy", 64'(arb_busy), 64'(e_busy));
    check("SM_log_length", 64'(sm_log_length), 64'(e_len));
    check("SM_address", 64'(sm_address), 64'(e_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    while (sm_request !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_request", 64'(sm_request), 64'd1);
  endtask

  task automatic measureHigh(output int n);
    n = 0;
    while (sm_request === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic measureLow(input int budget, output int n);
    n = 0;
    while (sm_request === 1'b0 && n < budget) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  l0, l1;
    logic [31:0] a0, a1;
    logic [1:0]  exp_grant;
    logic [4:0]  exp_len;
    logic [31:0] exp_addr;
    int          exp_window;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          n, gap;
    logic [1:0]  g;
    logic [1:0]  seq_grant[4];
    int          seq_win[4];
    logic [31:0] seq_addr[4];
    bit          any_req;

    vecs[0] = '{2'b01, 5'd3,  5'd0,  32'd10,         32'd0,          2'b01, 5'd3,  32'd10,         8};
    vecs[1] = '{2'b10, 5'd0,  5'd12, 32'd0,          32'h20,         2'b10, 5'd10, 32'h20,         1024};
    vecs[2] = '{2'b11, 5'd2,  5'd5,  32'hA5A5_0000,  32'h1234,       2'b01, 5'd2,  32'hA5A5_0000,  4};
    vecs[3] = '{2'b10, 5'd0,  5'd0,  32'd0,          32'hFFFF_FFFF,  2'b10, 5'd0,  32'hFFFF_FFFF,  1};
    vecs[4] = '{2'b01, 5'd10, 5'd0,  32'h40,         32'd0,          2'b01, 5'd10, 32'h40,         1024};

    // Reset with both requesters valid: outputs stay zero, requester 0 wins first.
    applyStimulus(1, 1, 2'b11, 5'd3, 5'd2, 32'd10, 32'd20);
    repeat (3) tick();
    check("reset_grant", 64'(arb_grant), 64'd0);
    check("reset_request", 64'(sm_request), 64'd0);
    applyStimulus(0, 1, 2'b11, 5'd3, 5'd2, 32'd10, 32'd20);
    tick();
    check("first_grant", 64'(arb_grant), 64'(2'b01));

    // Table of single transactions.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
      repeat (2) tick();
      applyStimulus(0, 1, vecs[i].valid, vecs[i].l0, vecs[i].l1, vecs[i].a0, vecs[i].a1);
      waitReq(5);
      check("vec_grant", 64'(arb_grant), 64'(vecs[i].exp_grant));
      check("vec_len", 64'(sm_log_length), 64'(vecs[i].exp_len));
      check("vec_addr", 64'(sm_address), 64'(vecs[i].exp_addr));
      g = arb_grant;
      measureHigh(n);
      check("vec_window", 64'(n), 64'(vecs[i].exp_window));
      check("vec_ack", 64'(req_ack), 64'(vecs[i].exp_grant));
      measureLow(20, gap);
      check("vec_gap", 64'(gap), 64'(GUARD + 1));
    end

    // Both requesters valid continuously: strict alternation.
    applyStimulus(1, 1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) tick();
    applyStimulus(0, 1, 2'b11, 5'd3, 5'd2, 32'd10, 32'd20);
    seq_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
    seq_win   = '{8, 4, 8, 4};
    seq_addr  = '{32'd10, 32'd20, 32'd10, 32'd20};
    for (int i = 0; i < 4; i++) begin
      waitReq(8);
      check("rr_grant", 64'(arb_grant), 64'(seq_grant[i]));
      check("rr_addr", 64'(sm_address), 64'(seq_addr[i]));
      measureHigh(n);
      check("rr_window", 64'(n), 64'(seq_win[i]));
      check("rr_ack", 64'(req_ack), 64'(seq_grant[i]));
    end

    // Enable and valid dropped mid-window: window completes, then no new grant.
    applyStimulus(1, 1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) tick();
    applyStimulus(0, 1, 2'b01, 5'd3, 5'd0, 32'd10, 32'd0);
    waitReq(5);
    repeat (2) tick();
    applyStimulus(0, 0, 2'b00, 5'd7, 5'd7, 32'd99, 32'd99);
    measureHigh(n);
    check("en_drop_window_rest", 64'(n), 64'd6);
    check("en_drop_ack", 64'(req_ack), 64'(2'b01));
    check("en_drop_addr_hold", 64'(sm_address), 64'd10);
    applyStimulus(0, 0, 2'b01, 5'd3, 5'd0, 32'd10, 32'd0);
    any_req = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sm_request === 1'b1) any_req = 1;
    end
    check("en_low_no_grant", 64'(any_req), 64'd0);
    applyStimulus(0, 1, 2'b01, 5'd3, 5'd0, 32'd10, 32'd0);
    tick();
    check("en_return_grant", 64'(arb_grant), 64'(2'b01));

    // Reset on cycle 4 of an 8-cycle window.
    applyStimulus(1, 1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) tick();
    applyStimulus(0, 1, 2'b01, 5'd3, 5'd2, 32'd10, 32'd20);
    waitReq(5);
    repeat (3) tick();
    applyStimulus(1, 1, 2'b11, 5'd3, 5'd2, 32'd10, 32'd20);
    tick();
    check("midreset_request", 64'(sm_request), 64'd0);
    check("midreset_grant", 64'(arb_grant), 64'd0);
    check("midreset_busy", 64'(arb_busy), 64'd0);
    check("midreset_ack", 64'(req_ack), 64'd0);
    applyStimulus(0, 1, 2'b11, 5'd3, 5'd2, 32'd10, 32'd20);
    tick();
    check("midreset_regrant", 64'(arb_grant), 64'(2'b01));

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] l0, l1;
      l0 = ($urandom_range(0, 49) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 4));
      l1 = ($urandom_range(0, 49) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 4));
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
                    2'($urandom), l0, l1, $urandom, $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
